// File: rtl/uart_tx_device_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, CTRL bit positions and serial engine states.
package uart_tx_device_pkg;

  localparam logic [31:0] DATA_OFS = 32'h0;
  localparam logic [31:0] CTRL_OFS = 32'h100;

  localparam int CTRL_READY = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_device_tx_fifo.sv
// Synchronous byte FIFO with extra-bit pointers for full/empty.
// The head entry is visible on o_dout without a read latency.
module tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + CW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter: DATA writes feed a byte
// FIFO, a serial engine drains it onto TXD, CTRL gives status/IE.
module uart_tx_device
  import uart_tx_device_pkg::*;
#(
  parameter int             BITS       = 32,
  parameter logic [BITS-1:0] BASE      = BITS'(32'hF0000030),
  parameter int             CLK_DIV    = 434,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            LOCK,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic            FLUSH,
  output logic            INTR,
  output logic            TXD
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BITS-1:0] A_DATA = BASE + BITS'(DATA_OFS);
  localparam logic [BITS-1:0] A_CTRL = BASE + BITS'(CTRL_OFS);

  tx_state_e     r_state, w_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_idx, w_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_txd, w_txd_nx;
  logic          r_ovr, r_ie, r_intr;

  logic            w_wr_data, w_wr_ctrl;
  logic            w_rd_data, w_rd_ctrl;
  logic            w_pop, w_push, w_wrap;
  logic            w_full, w_empty;
  logic [7:0]      w_head;
  logic [2:0]      w_idx_inc;
  logic [CW-1:0]   w_count;
  logic [BITS-1:0] w_rdata;
  logic            w_unused;

  assign w_wr_data = (ABUS == A_DATA) & WE & ~FLUSH;
  assign w_wr_ctrl = (ABUS == A_CTRL) & WE & ~FLUSH;
  assign w_rd_data = (ABUS == A_DATA) & ~WE;
  assign w_rd_ctrl = (ABUS == A_CTRL) & ~WE;
  assign w_push    = w_wr_data & ~w_full;
  assign w_unused  = ^DBUS[BITS-1:9];

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (LOCK),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (DBUS[7:0]),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_rd_data: w_rdata = BITS'(w_count) & BITS'(15);
      w_rd_ctrl: begin
        w_rdata[CTRL_READY] = ~w_full;
        w_rdata[CTRL_BUSY]  = (r_state != ST_IDLE) | ~w_empty;
        w_rdata[CTRL_OVR]   = r_ovr;
        w_rdata[CTRL_IE]    = r_ie;
      end
      default: ;
    endcase
  end

  assign DBUS = (w_rd_data | w_rd_ctrl) ? w_rdata : {BITS{1'bz}};

  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      r_ovr  <= 1'b0;
      r_ie   <= 1'b0;
      r_intr <= 1'b0;
    end else begin
      if (w_wr_data && w_full) r_ovr <= 1'b1;
      else if (w_wr_ctrl && DBUS[CTRL_OVR]) r_ovr <= 1'b0;
      if (w_wr_ctrl) r_ie <= DBUS[CTRL_IE];
      r_intr <= r_ie & ~w_full;
    end
  end

  assign INTR = r_intr;
  assign TXD  = r_txd;

  assign w_wrap    = (r_baud == BW'(CLK_DIV - 1));
  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = w_wrap ? '0 : r_baud + BW'(1);
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_txd_nx   = r_txd;
    w_pop      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_baud_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_head;
          w_txd_nx   = 1'b0;
          w_state_nx = ST_START;
        end
      end
      ST_START: begin
        if (w_wrap) begin
          w_idx_nx   = 3'd0;
          w_txd_nx   = r_shift[0];
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          if (r_idx == 3'd7) begin
            w_txd_nx   = 1'b1;
            w_state_nx = ST_STOP;
          end else begin
            w_idx_nx = w_idx_inc;
            w_txd_nx = r_shift[w_idx_inc];
          end
        end
      end
      ST_STOP: begin
        // Back-to-back frames: reload straight into START, no idle bit.
        if (w_wrap) begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_head;
            w_txd_nx   = 1'b0;
            w_state_nx = ST_START;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge LOCK) begin
    if (!LOCK) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_txd   <= w_txd_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_device.sv
// Scoreboard bench: stimulus queues expected frames, a TXD
// monitor pops and checks each frame sample by sample.
module tb_uart_tx_device;

  localparam int DIV = 4;
  localparam logic [31:0] A_DATA = 32'hF0000030;
  localparam logic [31:0] A_CTRL = 32'hF0000130;

  typedef struct {
    logic [7:0] b;
    bit         contig;
  } exp_t;

  logic        CLK, LOCK, WE, FLUSH;
  logic [31:0] ABUS;
  wire  [31:0] DBUS;
  logic        INTR, TXD;
  logic [31:0] tb_d;
  logic        tb_oe;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  assign DBUS = tb_oe ? tb_d : 32'bz;

  uart_tx_device #(
    .BITS(32), .BASE(32'hF0000030),
    .CLK_DIV(DIV), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .LOCK(LOCK), .ABUS(ABUS), .DBUS(DBUS),
    .WE(WE), .FLUSH(FLUSH), .INTR(INTR), .TXD(TXD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h req=%h", n, a, e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic fl);
    ABUS = a; tb_d = d; tb_oe = 1'b1; WE = 1'b1; FLUSH = fl;
    @(negedge CLK);
    WE = 1'b0; tb_oe = 1'b0; FLUSH = 1'b0; ABUS = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    ABUS = a; WE = 1'b0;
    #1;
    v = DBUS;
    ABUS = '0;
  endtask

  task automatic wait_idle(input int lim);
    logic [31:0] v;
    bit done;
    done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      @(negedge CLK);
      rd(A_CTRL, v);
      if (!v[1]) done = 1'b1;
    end
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  // TXD monitor: one expected entry per detected start bit
  initial begin
    int mcyc, last, nfr;
    exp_t e;
    logic [9:0] fr;
    logic [3:0] s;
    bit ab, have;
    mcyc = 0; last = -1000; nfr = 0;
    forever begin
      @(negedge CLK);
      mcyc++;
      if (LOCK && !TXD) begin
        have = exp_q.size() != 0;
        if (!have) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          e = '{8'h00, 1'b0};
        end else begin
          e = exp_q.pop_front();
        end
        if (have && e.contig)
          chk("frame_gap", 32'(mcyc - last), 32'd40);
        last = mcyc;
        fr = {1'b1, e.b, 1'b0};
        ab = 1'b0;
        s = '0;
        for (int b = 0; b < 10 && !ab; b++) begin
          for (int k = 0; k < DIV; k++) begin
            if (b != 0 || k != 0) begin
              @(negedge CLK);
              mcyc++;
            end
            if (!LOCK) begin
              ab = 1'b1;
              break;
            end
            s[k] = TXD;
          end
          if (!ab && have)
            chk($sformatf("fr%0d_bit%0d", nfr, b), 32'(s),
                32'({4{fr[b]}}));
        end
        nfr++;
      end
    end
  end

  initial begin
    logic [31:0] v;
    LOCK = 1'b0; WE = 1'b0; FLUSH = 1'b0;
    ABUS = '0; tb_d = '0; tb_oe = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_txd", 32'(TXD), 32'd1);
    chk("rst_intr", 32'(INTR), 32'd0);
    LOCK = 1'b1;
    @(negedge CLK);
    rd(A_CTRL, v);
    chk("rst_ctrl", v, 32'h1);

    // single byte, exact latency and frame length
    exp_q.push_back('{8'hA5, 1'b0});
    wr(A_DATA, 32'hA5, 1'b0);
    chk("a5_pre_fall", 32'(TXD), 32'd1);
    @(negedge CLK);
    chk("a5_fall", 32'(TXD), 32'd0);
    repeat (39) @(negedge CLK);
    rd(A_CTRL, v);
    chk("a5_busy_stop", v, 32'h3);
    @(negedge CLK);
    rd(A_CTRL, v);
    chk("a5_idle", v, 32'h1);

    // burst of six: one popped, four queued, sixth dropped
    exp_q.push_back('{8'h11, 1'b0});
    exp_q.push_back('{8'h22, 1'b1});
    exp_q.push_back('{8'h33, 1'b1});
    exp_q.push_back('{8'h44, 1'b1});
    exp_q.push_back('{8'h55, 1'b1});
    wr(A_DATA, 32'h11, 1'b0);
    wr(A_DATA, 32'h22, 1'b0);
    wr(A_DATA, 32'h33, 1'b0);
    wr(A_DATA, 32'h44, 1'b0);
    wr(A_DATA, 32'h55, 1'b0);
    wr(A_DATA, 32'h66, 1'b0);
    rd(A_CTRL, v);
    chk("ovr_ctrl", v, 32'h6);
    rd(A_DATA, v);
    chk("ovr_count", v, 32'h4);
    wait_idle(400);
    rd(A_CTRL, v);
    chk("ovr_sticky", v, 32'h5);
    @(negedge CLK);
    wr(A_CTRL, 32'h4, 1'b0);
    rd(A_CTRL, v);
    chk("ovr_clear", v, 32'h1);

    // flushed writes have no effect
    @(negedge CLK);
    wr(A_DATA, 32'h5A, 1'b1);
    rd(A_DATA, v);
    chk("flush_count", v, 32'h0);
    repeat (10) @(negedge CLK);
    chk("flush_txd", 32'(TXD), 32'd1);
    wr(A_CTRL, 32'h100, 1'b1);
    rd(A_CTRL, v);
    chk("flush_ie", v, 32'h1);
    @(negedge CLK);
    chk("flush_intr", 32'(INTR), 32'd0);

    // interrupt follows IE & READY one cycle late
    wr(A_CTRL, 32'h100, 1'b0);
    chk("intr_lag", 32'(INTR), 32'd0);
    @(negedge CLK);
    chk("intr_set", 32'(INTR), 32'd1);
    rd(A_CTRL, v);
    chk("ie_ctrl", v, 32'h101);
    @(negedge CLK);
    exp_q.push_back('{8'h01, 1'b0});
    exp_q.push_back('{8'h02, 1'b1});
    exp_q.push_back('{8'h03, 1'b1});
    exp_q.push_back('{8'h04, 1'b1});
    exp_q.push_back('{8'h05, 1'b1});
    wr(A_DATA, 32'h01, 1'b0);
    wr(A_DATA, 32'h02, 1'b0);
    wr(A_DATA, 32'h03, 1'b0);
    wr(A_DATA, 32'h04, 1'b0);
    wr(A_DATA, 32'h05, 1'b0);
    chk("intr_full_lag", 32'(INTR), 32'd1);
    @(negedge CLK);
    chk("intr_full", 32'(INTR), 32'd0);
    rd(A_CTRL, v);
    chk("full_ctrl", v, 32'h102);
    wait_idle(400);

    // reset mid-frame during data bit 3
    @(negedge CLK);
    exp_q.push_back('{8'h07, 1'b0});
    wr(A_DATA, 32'h07, 1'b0);
    wr(A_DATA, 32'h99, 1'b0);
    repeat (17) @(negedge CLK);
    chk("bit3_low", 32'(TXD), 32'd0);
    #2 LOCK = 1'b0;
    #1;
    chk("async_txd", 32'(TXD), 32'd1);
    chk("async_intr", 32'(INTR), 32'd0);
    repeat (2) @(negedge CLK);
    LOCK = 1'b1;
    @(negedge CLK);
    rd(A_DATA, v);
    chk("post_rst_count", v, 32'h0);
    rd(A_CTRL, v);
    chk("post_rst_ctrl", v, 32'h1);
    repeat (60) @(negedge CLK);
    chk("post_rst_txd", 32'(TXD), 32'd1);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
